// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller: clamps a 14-bit value to 9999, converts it to BCD
// with a serial double-dabble engine, and time-multiplexes the digits with leading-zero blanking.
module disp_scan_ctrl #(
   parameter int REFRESH_CNT = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [13:0] val_in,
   input  logic        val_valid,
   output logic        val_ready,
   output logic [3:0]  digit_bcd,
   output logic [3:0]  an,
   output logic        ovf
);

   localparam int RW = $clog2(REFRESH_CNT);

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t        state, state_nxt;
   logic [29:0]   sr, sr_nxt, sr_adj;
   logic [3:0]    scnt, scnt_nxt;
   logic          pend, pend_nxt;
   logic          disp_we;
   logic          clamp;
   logic [13:0]   operand;
   logic [15:0]   disp;
   logic [RW-1:0] rcnt;
   logic [1:0]    slot;
   logic          blank;

   always_comb begin
      clamp   = (val_in > 14'd9999);
      operand = clamp ? 14'd9999 : val_in;
   end

   // add-3 correction on every BCD nibble before the shift
   always_comb begin
      sr_adj = sr;
      for (int i = 0; i < 4; i++) begin
         if (sr[14+4*i +: 4] >= 4'd5)
            sr_adj[14+4*i +: 4] = sr[14+4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         scnt  <= '0;
         pend  <= 1'b0;
      end else begin
         state <= state_nxt;
         sr    <= sr_nxt;
         scnt  <= scnt_nxt;
         pend  <= pend_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sr_nxt    = sr;
      scnt_nxt  = scnt;
      pend_nxt  = pend;
      val_ready = 1'b0;
      disp_we   = 1'b0;
      case (state)
         IDLE: begin
            val_ready = 1'b1;
            if (val_valid) begin
               sr_nxt    = {16'b0, operand};
               scnt_nxt  = '0;
               pend_nxt  = clamp;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            sr_nxt   = {sr_adj[28:0], 1'b0};
            scnt_nxt = scnt + 4'd1;
            if (scnt == 4'd13)
               state_nxt = LATCH;
         end
         LATCH: begin
            disp_we   = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // whole-value update so the scan never shows a mix of old and new digits
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         disp <= '0;
         ovf  <= 1'b0;
      end else if (disp_we) begin
         disp <= sr[29:14];
         ovf  <= pend;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt <= '0;
         slot <= '0;
      end else if (rcnt == RW'(REFRESH_CNT - 1)) begin
         rcnt <= '0;
         slot <= slot + 2'd1;
      end else begin
         rcnt <= rcnt + RW'(1);
      end
   end

   always_comb begin
      digit_bcd = disp[4*slot +: 4];
      case (slot)
         2'd1:    blank = (disp[15:4] == 12'd0);
         2'd2:    blank = (disp[15:8] == 8'd0);
         2'd3:    blank = (disp[15:12] == 4'd0);
         default: blank = 1'b0;
      endcase
      an = blank ? 4'b1111 : ~(4'b0001 << slot);
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: stimulus queues expected BCD/ovf per accepted value,
// the monitor pops on each conversion completion and checks the scan every cycle.
module tb_disp_scan_ctrl;

   localparam int RC = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [13:0] val_in = '0;
   logic        val_valid = 1'b0;
   logic        val_ready;
   logic [3:0]  digit_bcd;
   logic [3:0]  an;
   logic        ovf;

   disp_scan_ctrl #(.REFRESH_CNT(RC)) dut (
      .clk       (clk),
      .rst       (rst),
      .val_in    (val_in),
      .val_valid (val_valid),
      .val_ready (val_ready),
      .digit_bcd (digit_bcd),
      .an        (an),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [16:0] expq[$];
   logic [15:0] m_disp = '0;
   logic        m_ovf = 1'b0;
   int          cyc = 0;
   int          lowcnt = 0;
   logic        prev_rdy = 1'b1;

   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [3:0] exp_an(input logic [15:0] d, input int s);
      if (s != 0 && (d >> (4 * s)) == 16'd0) return 4'b1111;
      case (s)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   // monitor
   always @(negedge clk) begin
      int          s;
      logic [3:0]  ea;
      logic [3:0]  ed;
      if (rst) begin
         n_cmp++;
         if (an !== 4'b1110 || digit_bcd !== 4'd0 || val_ready !== 1'b1 || ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_vals got an=%b dig=%h rdy=%b ovf=%b exp an=1110 dig=0 rdy=1 ovf=0",
                     an, digit_bcd, val_ready, ovf);
         end
         expq.delete();
         m_disp   = '0;
         m_ovf    = 1'b0;
         lowcnt   = 0;
         prev_rdy = 1'b1;
      end else begin
         if (val_ready === 1'b1 && prev_rdy === 1'b0) begin
            n_cmp++;
            if (lowcnt != 15) begin
               n_bad++;
               $display("FAIL ready_low got=%0d exp=15", lowcnt);
            end
            n_cmp++;
            if (expq.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_completion got=1 exp=0 at cyc=%0d", cyc);
            end else begin
               {m_disp, m_ovf} = expq.pop_front();
            end
         end
         lowcnt   = (val_ready === 1'b1) ? 0 : lowcnt + 1;
         prev_rdy = val_ready;
         s  = (cyc / RC) % 4;
         ea = exp_an(m_disp, s);
         ed = m_disp[4*s +: 4];
         n_cmp++;
         if (an !== ea || digit_bcd !== ed || ovf !== m_ovf) begin
            n_bad++;
            $display("FAIL scan cyc=%0d got an=%b dig=%h ovf=%b exp an=%b dig=%h ovf=%b",
                     cyc, an, digit_bcd, ovf, ea, ed, m_ovf);
         end
      end
   end

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_ready();
      int b = 0;
      while (val_ready !== 1'b1 && b < 100) begin
         @(negedge clk);
         b++;
      end
      n_cmp++;
      if (val_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL ready_timeout got=%b exp=1", val_ready);
      end
   endtask

   task automatic conv(input logic [13:0] v, input logic [16:0] e);
      wait_ready();
      val_in    = v;
      val_valid = 1'b1;
      expq.push_back(e);
      @(posedge clk);
      #1 val_valid = 1'b0;
      @(negedge clk);
      wait_ready();
      run(16);
   endtask

   initial begin
      int  n;
      logic r;
      #1 rst = 1'b1;
      run(3);
      #1 rst = 1'b0;
      run(16);

      conv(14'd1234,  {16'h1234, 1'b0});
      conv(14'd42,    {16'h0042, 1'b0});
      conv(14'd1005,  {16'h1005, 1'b0});
      conv(14'd12000, {16'h9999, 1'b1});
      conv(14'd7,     {16'h0007, 1'b0});
      conv(14'd0,     {16'h0000, 1'b0});
      conv(14'd9999,  {16'h9999, 1'b0});
      conv(14'd10000, {16'h9999, 1'b1});
      conv(14'd16383, {16'h9999, 1'b1});
      conv(14'd7,     {16'h0007, 1'b0});

      // back-to-back with val_valid held, then an ignored pulse mid-conversion
      wait_ready();
      val_in    = 14'd100;
      val_valid = 1'b1;
      expq.push_back({16'h0100, 1'b0});
      @(posedge clk);
      #1 val_in = 14'd200;
      expq.push_back({16'h0200, 1'b0});
      n = 0;
      r = 1'b0;
      while (!r && n < 40) begin
         @(negedge clk);
         r = val_ready;
         @(posedge clk);
         n++;
      end
      #1 val_valid = 1'b0;
      n_cmp++;
      if (n != 16) begin
         n_bad++;
         $display("FAIL b2b_accept_edge got=%0d exp=16", n);
      end
      repeat (4) @(posedge clk);
      #1 val_in = 14'd555;
      val_valid = 1'b1;
      @(posedge clk);
      #1 val_valid = 1'b0;
      @(negedge clk);
      wait_ready();
      run(16);

      // reset in the middle of a conversion
      wait_ready();
      val_in    = 14'd8888;
      val_valid = 1'b1;
      expq.push_back({16'h8888, 1'b0});
      @(posedge clk);
      #1 val_valid = 1'b0;
      repeat (7) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (an !== 4'b1110 || digit_bcd !== 4'd0 || val_ready !== 1'b1 || ovf !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_immediate got an=%b dig=%h rdy=%b ovf=%b exp an=1110 dig=0 rdy=1 ovf=0",
                  an, digit_bcd, val_ready, ovf);
      end
      run(2);
      #1 rst = 1'b0;
      run(40);

      conv(14'd5678, {16'h5678, 1'b0});

      n_cmp++;
      if (expq.size() != 0) begin
         n_bad++;
         $display("FAIL queue_empty got=%0d exp=0", expq.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
